// File: rtl/lsu_mem_arbiter.sv
// rtl/lsu_mem_arbiter.sv - round-robin arbiter sharing one data-memory channel among LSUs
// One read or write is in flight at a time; completion is held to the LSU until it drops valid.
module lsu_mem_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAY,
    WRITE_RELAY
  } state_t;

  state_t              state;
  logic [IDX_BITS-1:0] rr_ptr;
  logic [IDX_BITS-1:0] cur;
  logic [IDX_BITS-1:0] pick;
  logic [IDX_BITS-1:0] scan_idx;
  logic [IDX_BITS-1:0] next_ptr;
  logic                found;

  // First requester at or after rr_ptr, wrapping modulo NUM_CONSUMERS.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (int'(rr_ptr) + k >= NUM_CONSUMERS)
        scan_idx = IDX_BITS'(int'(rr_ptr) + k - NUM_CONSUMERS);
      else
        scan_idx = IDX_BITS'(int'(rr_ptr) + k);
      if (!found && (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  assign next_ptr = (cur == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0 : cur + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      cur                  <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            cur <= pick;
            // A read wins over a write from the same LSU; the write waits for a later grant.
            if (consumer_read_valid[pick]) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
              state            <= READ_WAITING;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[pick*ADDR_BITS +: ADDR_BITS];
              mem_write_data    <= consumer_write_data[pick*DATA_BITS +: DATA_BITS];
              state             <= WRITE_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid                                <= 1'b0;
            consumer_read_data[cur*DATA_BITS +: DATA_BITS] <= mem_read_data;
            consumer_read_ready[cur]                      <= 1'b1;
            state                                         <= READ_RELAY;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready) begin
            mem_write_valid           <= 1'b0;
            consumer_write_ready[cur] <= 1'b1;
            state                     <= WRITE_RELAY;
          end
        end
        READ_RELAY: begin
          if (!consumer_read_valid[cur]) begin
            consumer_read_ready[cur] <= 1'b0;
            rr_ptr                   <= next_ptr;
            state                    <= IDLE;
          end
        end
        WRITE_RELAY: begin
          if (!consumer_write_valid[cur]) begin
            consumer_write_ready[cur] <= 1'b0;
            rr_ptr                    <= next_ptr;
            state                     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// tb/tb_lsu_mem_arbiter.sv - scoreboard bench for lsu_mem_arbiter
// Expected memory transactions are queued in grant order and popped as the DUT issues them.
module tb_lsu_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    consumer_read_valid;
  logic [N*AW-1:0] consumer_read_address;
  logic [N-1:0]    consumer_read_ready;
  logic [N*DW-1:0] consumer_read_data;
  logic [N-1:0]    consumer_write_valid;
  logic [N*AW-1:0] consumer_write_address;
  logic [N*DW-1:0] consumer_write_data;
  logic [N-1:0]    consumer_write_ready;
  logic            mem_read_valid;
  logic [AW-1:0]   mem_read_address;
  logic            mem_read_ready;
  logic [DW-1:0]   mem_read_data;
  logic            mem_write_valid;
  logic [AW-1:0]   mem_write_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_write_ready;

  always #5 clk = ~clk;

  lsu_mem_arbiter #(.ADDR_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N)) dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
    .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
    .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
    .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  logic [16:0] sb[$];  // {is_write, address, write data (0 for reads)}

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
    sb.push_back({w, a, d});
  endtask

  function automatic logic [7:0] mem_val(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  // Memory model: read ready after rd_delay cycles, write ready after wr_delay cycles.
  bit mem_auto = 1'b1;
  int rd_delay = 0;
  int wr_delay = 2;
  initial begin
    int rcnt = 0;
    int wcnt = 0;
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'hEE;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = 8'hEE;
        if (mem_read_valid && rcnt == rd_delay) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem_val(mem_read_address);
          rcnt = 0;
        end else rcnt = mem_read_valid ? rcnt + 1 : 0;
        if (mem_write_valid && wcnt == wr_delay) begin
          mem_write_ready = 1'b1;
          wcnt = 0;
        end else wcnt = mem_write_valid ? wcnt + 1 : 0;
      end
    end
  end

  // Grant monitor and channel invariants.
  initial begin
    logic prev_r = 1'b0, prev_w = 1'b0, prev_rr = 1'b0, prev_wr = 1'b0;
    logic [16:0] exp;
    forever begin
      @(negedge clk);
      check("rw_exclusive", {31'd0, mem_read_valid & mem_write_valid}, 32'd0);
      check("ready_onehot0", {31'd0, $onehot0(consumer_read_ready | consumer_write_ready)}, 32'd1);
      if (!reset && prev_r && !mem_read_valid) check("rd_valid_held", {31'd0, prev_rr}, 32'd1);
      if (!reset && prev_w && !mem_write_valid) check("wr_valid_held", {31'd0, prev_wr}, 32'd1);
      if (mem_read_valid && !prev_r) begin
        exp = (sb.size() != 0) ? sb.pop_front() : 17'h1FFFF;
        check("sb_read", {15'd0, 1'b0, mem_read_address, 8'h00}, {15'd0, exp});
      end
      if (mem_write_valid && !prev_w) begin
        exp = (sb.size() != 0) ? sb.pop_front() : 17'h1FFFF;
        check("sb_write", {15'd0, 1'b1, mem_write_address, mem_write_data}, {15'd0, exp});
      end
      prev_r  = mem_read_valid;
      prev_w  = mem_write_valid;
      prev_rr = mem_read_ready;
      prev_wr = mem_write_ready;
    end
  end

  task automatic do_read(input int i, input logic [7:0] a, input int hold, input int lat);
    int n = 0;
    bit scr = 1'b0;
    consumer_read_address[i*AW +: AW] = a;
    consumer_read_valid[i] = 1'b1;
    while (n < 200 && !consumer_read_ready[i]) begin
      @(negedge clk);
      n++;
      // Changing the address after grant must not disturb the request in flight.
      if (!scr && mem_read_valid && mem_read_address == a) begin
        consumer_read_address[i*AW +: AW] = ~a;
        scr = 1'b1;
      end
    end
    check($sformatf("rd%0d_ready", i), {31'd0, consumer_read_ready[i]}, 32'd1);
    if (lat > 0) check("rd_latency", n, lat);
    check($sformatf("rd%0d_data", i), {24'd0, consumer_read_data[i*DW +: DW]}, {24'd0, mem_val(a)});
    repeat (hold) begin
      @(negedge clk);
      check("rd_hold", {31'd0, consumer_read_ready[i]}, 32'd1);
    end
    consumer_read_valid[i] = 1'b0;
    @(negedge clk);
    check($sformatf("rd%0d_clear", i), {31'd0, consumer_read_ready[i]}, 32'd0);
  endtask

  task automatic do_write(input int i, input logic [7:0] a, input logic [7:0] d, input int hold);
    int n = 0;
    bit scr = 1'b0;
    consumer_write_address[i*AW +: AW] = a;
    consumer_write_data[i*DW +: DW]    = d;
    consumer_write_valid[i] = 1'b1;
    while (n < 200 && !consumer_write_ready[i]) begin
      @(negedge clk);
      n++;
      if (!scr && mem_write_valid && mem_write_address == a) begin
        consumer_write_address[i*AW +: AW] = ~a;
        consumer_write_data[i*DW +: DW]    = ~d;
        scr = 1'b1;
      end
    end
    check($sformatf("wr%0d_ready", i), {31'd0, consumer_write_ready[i]}, 32'd1);
    repeat (hold) begin
      @(negedge clk);
      check("wr_hold", {31'd0, consumer_write_ready[i]}, 32'd1);
    end
    consumer_write_valid[i] = 1'b0;
    @(negedge clk);
    check($sformatf("wr%0d_clear", i), {31'd0, consumer_write_ready[i]}, 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset                  = 1'b1;
    consumer_read_valid    = '0;
    consumer_read_address  = '0;
    consumer_write_valid   = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_mem_rv", {31'd0, mem_read_valid}, 32'd0);
    check("rst_mem_wv", {31'd0, mem_write_valid}, 32'd0);
    check("rst_rd_ready", {28'd0, consumer_read_ready}, 32'd0);
    check("rst_wr_ready", {28'd0, consumer_write_ready}, 32'd0);
    check("rst_rd_data", consumer_read_data, 32'd0);
    check("rst_mem_waddr", {16'd0, mem_write_address, mem_write_data}, 32'd0);

    // Single read with a two-edge latency, then single write.
    push(1'b0, 8'h10, 8'h00);
    do_read(2, 8'h10, 2, 2);
    push(1'b1, 8'h20, 8'h3C);
    do_write(1, 8'h20, 8'h3C, 1);

    // Round robin from a fresh pointer, then wrap back to LSU0.
    apply_reset();
    for (int i = 0; i < N; i++) push(1'b0, 8'h40 + 8'(i), 8'h00);
    fork
      do_read(0, 8'h40, 0, 0);
      do_read(1, 8'h41, 0, 0);
      do_read(2, 8'h42, 0, 0);
      do_read(3, 8'h43, 0, 0);
    join
    push(1'b0, 8'h50, 8'h00);
    push(1'b0, 8'h53, 8'h00);
    fork
      do_read(0, 8'h50, 0, 0);
      do_read(3, 8'h53, 0, 0);
    join

    // LSU0 re-requests back to back; LSU1 must get in between.
    push(1'b0, 8'h60, 8'h00);
    push(1'b0, 8'h71, 8'h00);
    push(1'b0, 8'h62, 8'h00);
    fork
      begin
        do_read(0, 8'h60, 0, 0);
        do_read(0, 8'h62, 0, 0);
      end
      begin
        @(negedge clk);
        do_read(1, 8'h71, 0, 0);
      end
    join

    // Same LSU asserts read and write together: read first.
    push(1'b0, 8'h05, 8'h00);
    push(1'b1, 8'h05, 8'h77);
    fork
      do_read(0, 8'h05, 1, 0);
      do_write(0, 8'h05, 8'h77, 0);
    join

    // Reset while READ_WAITING, then a late memory ready.
    mem_auto       = 1'b0;
    mem_read_ready = 1'b0;
    push(1'b0, 8'h30, 8'h00);
    consumer_read_address[2*AW +: AW] = 8'h30;
    consumer_read_valid[2] = 1'b1;
    n = 0;
    while (n < 20 && !mem_read_valid) begin
      @(negedge clk);
      n++;
    end
    check("t6_granted", {31'd0, mem_read_valid}, 32'd1);
    reset = 1'b1;
    consumer_read_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("t6_rst_rv", {31'd0, mem_read_valid}, 32'd0);
    check("t6_rst_rdata", consumer_read_data, 32'd0);
    mem_read_data  = 8'hFF;
    mem_read_ready = 1'b1;
    @(negedge clk);
    mem_read_ready = 1'b0;
    @(negedge clk);
    check("t6_late_ready", {28'd0, consumer_read_ready | consumer_write_ready}, 32'd0);
    check("t6_late_rdata", consumer_read_data, 32'd0);
    check("t6_late_valid", {30'd0, mem_read_valid, mem_write_valid}, 32'd0);
    mem_auto = 1'b1;
    push(1'b0, 8'h80, 8'h00);
    push(1'b0, 8'h83, 8'h00);
    fork
      do_read(0, 8'h80, 0, 0);
      do_read(3, 8'h83, 0, 0);
    join

    @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_arbiter.md
Name: lsu_mem_arbiter

Overview:
- Shares one data-memory channel among NUM_CONSUMERS per-thread LSUs in a core.
- Uses round-robin grant and serialises one read or write transaction at a time.
- Relays the valid/ready handshake on both sides: LSU-facing ports mirror the LSU read/write valid, address, data and ready signals; memory-facing ports drive the single data-memory channel.

Parameters:
ADDR_BITS, 8, address width on both sides
DATA_BITS, 8, data width on both sides
NUM_CONSUMERS, 4, number of LSU requesters; any value >= 1, power of two not required

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request
consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  packed; slice i belongs to LSU i
consumer_read_ready  out  NUM_CONSUMERS  per-LSU read completion
consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  packed read data
consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request
consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  packed write address
consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  packed write data
consumer_write_ready  out  NUM_CONSUMERS  per-LSU write completion
mem_read_valid  out  1  read request to memory
mem_read_address  out  ADDR_BITS  read address
mem_read_ready  in  1  memory read done; mem_read_data valid in the same cycle
mem_read_data  in  DATA_BITS  memory read data
mem_write_valid  out  1  write request to memory
mem_write_address  out  ADDR_BITS  write address
mem_write_data  out  DATA_BITS  write data
mem_write_ready  in  1  memory write done

Behaviour:
- Interface is fixed: single clock clk; reset is synchronous and active-high. All outputs are registered.
- Reset: all outputs go to 0, state to IDLE, rr_ptr to 0, cur to 0.
- Reset mid-transaction aborts the transaction. mem_*_valid and all consumer_*_ready are 0 after the edge. A late memory ready is ignored.
- State machine has five states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAY, WRITE_RELAY.
- IDLE:
  - Scan indices rr_ptr, rr_ptr+1, ... with wrap modulo NUM_CONSUMERS.
  - Grant the first i with consumer_read_valid[i] or consumer_write_valid[i]; cur <= i.
  - Read grant: mem_read_valid <= 1, mem_read_address <= slice i; go to READ_WAITING.
  - Write grant: mem_write_valid <= 1, latch address and data slices; go to WRITE_WAITING.
  - If read and write are both valid on the same i, the read wins. The write is served in a later grant.
  - No request: stay in IDLE.
- READ_WAITING: when mem_read_ready == 1:
  - mem_read_valid <= 0.
  - consumer_read_data[cur] <= mem_read_data and consumer_read_ready[cur] <= 1.
  - Go to READ_RELAY. Otherwise hold all outputs.
- WRITE_WAITING: when mem_write_ready == 1: mem_write_valid <= 0, consumer_write_ready[cur] <= 1, go to WRITE_RELAY.
- READ_RELAY / WRITE_RELAY: hold ready[cur] high until the corresponding consumer valid[cur] == 0. Then:
  - ready[cur] <= 0.
  - rr_ptr <= (cur == NUM_CONSUMERS-1) ? 0 : cur+1.
  - Go to IDLE.
- Latency with memory ready asserted in the same cycle valid rises:
  - Consumer valid seen at edge 0; mem valid high after edge 0.
  - Consumer ready high after edge 1.
  - After the consumer drops valid, ready clears one edge later.
- Consumer address/data are sampled only at grant. Later changes do not affect the in-flight request.
- consumer_read_data[i] holds its last value and is not cleared when ready drops. Unselected slices are never written.
- Memory ready while mem valid is 0 is ignored. Ready for the opposite direction is ignored.
- Protocol violation: consumer drops valid before ready. The memory transaction still completes. The relay state sees valid low and exits on the next edge, so ready pulses for exactly one cycle.
- Fairness: a requester holding valid waits at most NUM_CONSUMERS-1 other transactions before grant.
- At most one of mem_read_valid and mem_write_valid is 1 in any cycle.
- At most one bit of consumer_read_ready | consumer_write_ready is 1 in any cycle.

Test Plan:
1. Single read: LSU2 reads addr 0x10; memory returns 0xA5 with ready one cycle after valid. Required: mem_read_address=0x10, consumer_read_data[2]=0xA5, consumer_read_ready[2] high until LSU2 drops valid, then 0 one edge later.
2. Single write: LSU1 writes 0x3C to 0x20. Required: mem_write_address=0x20, mem_write_data=0x3C; mem_write_valid held until ready; consumer_write_ready[1] pulses per the relay rule.
3. Round robin: LSUs 0–3 all request reads simultaneously after reset. Required: grant order 0,1,2,3. Then, with LSU0 and LSU3 re-requesting after LSU3 is served, LSU0 is granted next (pointer wrap).
4. Starvation check: LSU0 re-requests immediately after every completion while LSU1 waits. Required: LSU1 is granted before LSU0's second transaction.
5. Same-LSU read+write: LSU0 asserts both, addr 0x05. Required: read serviced first, write second; mem read/write valids never high together.
6. Reset mid-operation: assert reset during READ_WAITING, then pulse mem_read_ready. Required: all outputs 0, no consumer ready, and the next grant starts at LSU0.
